// File: rtl/idli_mem_sched_m.sv
// idli_mem_sched_m
//
// Arbitrates the single SQI memory port between instruction fetch and
// load/store. It tracks which transaction is in flight. It drives the restart,
// address-select, shift-register write and direction controls of the SQI
// controller. It returns data-valid and acknowledge strobes to the core.
// Every decision is taken on a period boundary. A period is 4 cycles, and its
// final cycle is flagged by i_sched_last_cycle.
//
// Ports
//   i_sched_gck         core clock
//   i_sched_rst_n       asynchronous active-low reset
//   i_sched_last_cycle  high on the final cycle of each 4-cycle period
//   i_sched_br_req      fetch redirect request, held until br_ack
//   i_sched_mem_req     load/store request, held until mem_ack
//   i_sched_mem_wr      1 = store, 0 = load (valid with mem_req)
//   o_sched_br_ack      redirect accepted; core writes the target into PC
//   o_sched_mem_ack     load/store data period complete
//   o_sched_restart     force the SQI FSM to INIT at this boundary
//   o_sched_addr_wr     shift-register write enable (address load)
//   o_sched_addr_sel    0 = PC, 1 = load/store address
//   o_sched_rd          SQI direction: 1 = read, 0 = write
//   o_sched_fetch_vld   current period carries instruction nibbles
//
// SETUP_PERIODS is the number of periods from restart to the first data
// period (INIT, ADDR, DUMMY). The phase counter is 2 bits wide, so the
// parameter must be in the range 1..4.

module idli_mem_sched_m #(
  parameter int SETUP_PERIODS = 3
) (
  input  logic i_sched_gck,
  input  logic i_sched_rst_n,
  input  logic i_sched_last_cycle,
  input  logic i_sched_br_req,
  input  logic i_sched_mem_req,
  input  logic i_sched_mem_wr,
  output logic o_sched_br_ack,
  output logic o_sched_mem_ack,
  output logic o_sched_restart,
  output logic o_sched_addr_wr,
  output logic o_sched_addr_sel,
  output logic o_sched_rd,
  output logic o_sched_fetch_vld
);

  typedef enum logic [1:0] {
    FSETUP = 2'd0,
    FETCH  = 2'd1,
    MSETUP = 2'd2,
    MDATA  = 2'd3
  } state_t;

  localparam logic [1:0] LAST_PHASE = 2'(SETUP_PERIODS - 1);

  state_t     state_reg, state_next;
  logic [1:0] phase_reg, phase_next;
  logic       wr_reg, wr_next;
  logic       boundary;

  // State advances only at period boundaries; everything else is held.
  always_ff @(posedge i_sched_gck or negedge i_sched_rst_n) begin
    if (!i_sched_rst_n) begin
      state_reg <= FSETUP;
      phase_reg <= 2'd0;
      wr_reg    <= 1'b0;
    end else if (i_sched_last_cycle) begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      wr_reg    <= wr_next;
    end
  end

  // The boundary strobes are qualified with reset. This keeps an ack from
  // escaping while reset is asserted, because the outputs also depend
  // combinationally on the request inputs.
  assign boundary = i_sched_last_cycle & i_sched_rst_n;

  always_comb begin
    state_next        = state_reg;
    phase_next        = phase_reg;
    wr_next           = wr_reg;
    o_sched_br_ack    = 1'b0;
    o_sched_mem_ack   = 1'b0;
    o_sched_restart   = 1'b0;
    o_sched_addr_wr   = 1'b0;
    o_sched_addr_sel  = 1'b0;
    o_sched_rd        = 1'b1;
    o_sched_fetch_vld = 1'b0;

    case (state_reg)
      FSETUP: begin
        o_sched_addr_wr = (phase_reg == 2'd0);
        if (i_sched_br_req) begin
          // A redirect restarts the setup sequence on the new PC.
          o_sched_br_ack  = boundary;
          o_sched_restart = boundary;
          phase_next      = 2'd0;
        end else if (phase_reg == LAST_PHASE) begin
          state_next = FETCH;
          phase_next = 2'd0;
        end else begin
          phase_next = phase_reg + 2'd1;
        end
      end

      FETCH: begin
        o_sched_fetch_vld = 1'b1;
        // Load/store takes priority over a pending redirect. The redirect
        // stays held and is taken at the next FSETUP boundary.
        if (i_sched_mem_req) begin
          o_sched_restart = boundary;
          wr_next         = i_sched_mem_wr;
          state_next      = MSETUP;
          phase_next      = 2'd0;
        end else if (i_sched_br_req) begin
          o_sched_br_ack  = boundary;
          o_sched_restart = boundary;
          state_next      = FSETUP;
          phase_next      = 2'd0;
        end
      end

      MSETUP: begin
        o_sched_addr_sel = 1'b1;
        o_sched_rd       = ~wr_reg;
        o_sched_addr_wr  = (phase_reg == 2'd0);
        if (phase_reg == LAST_PHASE) begin
          state_next = MDATA;
          phase_next = 2'd0;
        end else begin
          phase_next = phase_reg + 2'd1;
        end
      end

      MDATA: begin
        o_sched_addr_sel = 1'b1;
        o_sched_rd       = ~wr_reg;
        o_sched_mem_ack  = boundary;
        o_sched_restart  = boundary;
        // Fetch resumes from the unchanged PC after a fresh setup.
        state_next       = FSETUP;
        phase_next       = 2'd0;
      end

      default: begin
        state_next = FSETUP;
        phase_next = 2'd0;
      end
    endcase
  end

  // Period framing is broken if last_cycle is ever high on two cycles in a row.
  last_cycle_isolated : assert property (
    @(posedge i_sched_gck) disable iff (!i_sched_rst_n)
      i_sched_last_cycle |=> !i_sched_last_cycle
  );

endmodule

// File: tb/tb_idli_mem_sched_m.sv
// Directed testbench for idli_mem_sched_m.
// Cycle n is the interval that starts at the n-th rising edge after reset is
// released. Inputs are driven 1 ns after the rising edge, and outputs are
// sampled on the falling edge.
// The outputs are compared as the vector
// {br_ack, mem_ack, restart, addr_wr, addr_sel, rd, fetch_vld}.

module tb_idli_mem_sched_m;

  logic clk = 1'b0;
  logic rst_n;
  logic last_cycle;
  logic br_req;
  logic mem_req;
  logic mem_wr;
  logic br_ack, mem_ack, restart, addr_wr, addr_sel, rd, fetch_vld;
  logic [6:0] outs;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [6:0] RESET_VEC = 7'b0001010;

  always #5 clk = ~clk;

  assign outs = {br_ack, mem_ack, restart, addr_wr, addr_sel, rd, fetch_vld};

  idli_mem_sched_m #(.SETUP_PERIODS(3)) dut (
    .i_sched_gck        (clk),
    .i_sched_rst_n      (rst_n),
    .i_sched_last_cycle (last_cycle),
    .i_sched_br_req     (br_req),
    .i_sched_mem_req    (mem_req),
    .i_sched_mem_wr     (mem_wr),
    .o_sched_br_ack     (br_ack),
    .o_sched_mem_ack    (mem_ack),
    .o_sched_restart    (restart),
    .o_sched_addr_wr    (addr_wr),
    .o_sched_addr_sel   (addr_sel),
    .o_sched_rd         (rd),
    .o_sched_fetch_vld  (fetch_vld)
  );

  // Holds reset across two edges. Reset is released 1 ns after an edge, so
  // the next cycle is cycle 0.
  task automatic do_reset();
    rst_n      = 1'b0;
    br_req     = 1'b0;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    last_cycle = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    br_req     = 1'b0;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    last_cycle = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (outs !== RESET_VEC) begin
      miscompares++;
      $display("FAIL reset_idle got=%b exp=%b", outs, RESET_VEC);
    end
    // While reset is asserted, requests on a boundary must not produce strobes.
    br_req     = 1'b1;
    mem_req    = 1'b1;
    last_cycle = 1'b1;
    #1;
    vectors++;
    if (outs !== RESET_VEC) begin
      miscompares++;
      $display("FAIL reset_req got=%b exp=%b", outs, RESET_VEC);
    end
    @(posedge clk);
    #1;
    br_req     = 1'b0;
    mem_req    = 1'b0;
    last_cycle = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_fetch_setup();
    logic [6:0] e;
    do_reset();
    for (int n = 0; n < 16; n++) begin
      last_cycle = (n % 4 == 3);
      @(negedge clk);
      e = {1'b0, 1'b0, 1'b0, (n <= 3), 1'b0, 1'b1, (n >= 12)};
      vectors++;
      if (outs !== e) begin
        miscompares++;
        $display("FAIL fetch_setup cyc=%0d got=%b exp=%b", n, outs, e);
      end
      @(posedge clk);
      #1;
    end
    $display("test_fetch_setup done");
  endtask

  // A load (wr=0) or a store (wr=1) is requested from cycle 16 and held
  // until its ack at cycle 35.
  task automatic test_mem(input logic wr);
    logic [6:0] e, m;
    logic rd_e;
    do_reset();
    for (int n = 0; n < 52; n++) begin
      mem_req    = (n >= 16 && n <= 35);
      mem_wr     = wr;
      last_cycle = (n % 4 == 3);
      @(negedge clk);
      rd_e = wr ? !(n >= 20 && n <= 35) : 1'b1;
      e = {1'b0, (n == 35), (n == 19 || n == 35),
           (n <= 3 || (n >= 20 && n <= 23) || (n >= 36 && n <= 39)),
           (n >= 20 && n <= 35), rd_e,
           ((n >= 12 && n <= 19) || n >= 48)};
      // Address select is not defined during the data period, so it is
      // masked there.
      m = (n >= 32 && n <= 35) ? 7'b1111011 : 7'b1111111;
      vectors++;
      if ((outs & m) !== (e & m)) begin
        miscompares++;
        $display("FAIL %s cyc=%0d got=%b exp=%b", wr ? "store" : "load", n, outs, e);
      end
      @(posedge clk);
      #1;
    end
    mem_req = 1'b0;
    $display("test_mem wr=%0b done", wr);
  endtask

  task automatic test_br_mem_collide();
    logic [6:0] e, m;
    do_reset();
    for (int n = 0; n < 56; n++) begin
      mem_req    = (n >= 16 && n <= 35);
      mem_wr     = 1'b0;
      br_req     = (n >= 16 && n <= 39);
      last_cycle = (n % 4 == 3);
      @(negedge clk);
      e = {(n == 39), (n == 35), (n == 19 || n == 35 || n == 39),
           (n <= 3 || (n >= 20 && n <= 23) || (n >= 36 && n <= 43)),
           (n >= 20 && n <= 35), 1'b1,
           ((n >= 12 && n <= 19) || n >= 52)};
      m = (n >= 32 && n <= 35) ? 7'b1111011 : 7'b1111111;
      vectors++;
      if ((outs & m) !== (e & m)) begin
        miscompares++;
        $display("FAIL br_mem_collide cyc=%0d got=%b exp=%b", n, outs, e);
      end
      @(posedge clk);
      #1;
    end
    br_req  = 1'b0;
    mem_req = 1'b0;
    $display("test_br_mem_collide done");
  endtask

  task automatic test_br_fsetup();
    logic [6:0] e;
    do_reset();
    for (int n = 0; n < 24; n++) begin
      br_req     = (n >= 5 && n <= 7);
      last_cycle = (n % 4 == 3);
      @(negedge clk);
      e = {(n == 7), 1'b0, (n == 7), (n <= 3 || (n >= 8 && n <= 11)),
           1'b0, 1'b1, (n >= 20)};
      vectors++;
      if (outs !== e) begin
        miscompares++;
        $display("FAIL br_fsetup cyc=%0d got=%b exp=%b", n, outs, e);
      end
      @(posedge clk);
      #1;
    end
    br_req = 1'b0;
    $display("test_br_fsetup done");
  endtask

  // A mem_req is dropped before any boundary, so it has no effect. A
  // redirect taken in FETCH then re-runs the setup.
  task automatic test_fetch_br();
    logic [6:0] e;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      mem_req    = (n >= 16 && n <= 17);
      mem_wr     = 1'b1;
      br_req     = (n >= 21 && n <= 23);
      last_cycle = (n % 4 == 3);
      @(negedge clk);
      e = {(n == 23), 1'b0, (n == 23), (n <= 3 || (n >= 24 && n <= 27)),
           1'b0, 1'b1, ((n >= 12 && n <= 23) || n >= 36)};
      vectors++;
      if (outs !== e) begin
        miscompares++;
        $display("FAIL fetch_br cyc=%0d got=%b exp=%b", n, outs, e);
      end
      @(posedge clk);
      #1;
    end
    br_req  = 1'b0;
    mem_req = 1'b0;
    $display("test_fetch_br done");
  endtask

  task automatic test_reset_mid();
    logic [6:0] e;
    do_reset();
    for (int n = 0; n < 25; n++) begin
      mem_req    = (n >= 16);
      mem_wr     = 1'b1;
      last_cycle = (n % 4 == 3);
      @(negedge clk);
      e = {1'b0, 1'b0, (n == 19), (n <= 3 || (n >= 20 && n <= 23)),
           (n >= 20), !(n >= 20), (n >= 12 && n <= 19)};
      vectors++;
      if (outs !== e) begin
        miscompares++;
        $display("FAIL reset_mid_pre cyc=%0d got=%b exp=%b", n, outs, e);
      end
      @(posedge clk);
      #1;
    end
    // This is cycle 25, during MSETUP. Reset must take effect without a clock
    // edge.
    last_cycle = 1'b0;
    rst_n      = 1'b0;
    #1;
    vectors++;
    if (outs !== RESET_VEC) begin
      miscompares++;
      $display("FAIL reset_mid_async got=%b exp=%b", outs, RESET_VEC);
    end
    mem_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 16; n++) begin
      last_cycle = (n % 4 == 3);
      @(negedge clk);
      e = {1'b0, 1'b0, 1'b0, (n <= 3), 1'b0, 1'b1, (n >= 12)};
      vectors++;
      if (outs !== e) begin
        miscompares++;
        $display("FAIL reset_mid_post cyc=%0d got=%b exp=%b", n, outs, e);
      end
      @(posedge clk);
      #1;
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_fetch_setup();
    test_mem(1'b0);
    test_mem(1'b1);
    test_br_mem_collide();
    test_br_fsetup();
    test_fetch_br();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
